// File: rtl/mux_pkg.sv
// Shared definitions for the datapath operand multiplexers: the mode
// encoding of the select input and the default channel geometry.
package mux_pkg;

  // Encoding of the mode input.
  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_e;

  // Default geometry shared with the other datapath muxes.
  localparam int MUX_WIDTH_DEFAULT = 32;
  localparam int MUX_NUM_DEFAULT   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: returns the first requesting index found when
// scanning ptr, ptr+1, ... wrapping at NUM. Purely combinational; the
// owner keeps the pointer register.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NUM  = MUX_NUM_DEFAULT,
  localparam int SELW = $clog2(NUM)
) (
  input  logic [NUM-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  // Two passes: indices at or above ptr first, then the wrapped-around
  // indices below ptr. This avoids a modulo and works for any NUM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before
    // any conditional assignment, otherwise a latch is inferred.
    logic found;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int i = 0; i < NUM; i++) begin
      if (!found && req[i] && (SELW'(i) >= ptr)) begin
        idx   = SELW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      if (!found && req[i]) begin
        idx   = SELW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-input, W-bit selector with one registered output stage and valid/ready
// on every channel and on the output. Selects by explicit index (direct
// mode) or, when built with MUX_SEL_PIPE_RR_EN, by round-robin over the
// requesting channels. Without MUX_SEL_PIPE_RR_EN the mode input is
// ignored and no arbiter or pointer exists.
module mux_sel_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = MUX_WIDTH_DEFAULT,
  parameter  int NUM   = MUX_NUM_DEFAULT,
  localparam int SELW  = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM*WIDTH-1:0] in_data,
  input  logic [NUM-1:0]       in_valid,
  output logic [NUM-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;

  logic             w_free;
  logic             w_sel_valid;
  logic             w_hit;
  logic             w_grant;
  logic [SELW-1:0]  w_cand;
  logic [WIDTH-1:0] w_cand_data;

  // The output register can take a new beat when empty or being drained.
  assign w_free = !r_out_valid || out_ready;

  // Valid bit of the directly selected channel; an index beyond the last
  // channel matches nothing and therefore never grants.
  always_comb begin
    w_sel_valid = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (sel == SELW'(i)) w_sel_valid = in_valid[i];
    end
  end

`ifdef MUX_SEL_PIPE_RR_EN
  logic [SELW-1:0] r_ptr;
  logic            w_rr_mode;
  logic            w_rr_any;
  logic [SELW-1:0] w_rr_idx;

  assign w_rr_mode = (mode == MODE_RR);

  rr_arbiter #(.NUM(NUM)) u_rr_arbiter (
    .req (in_valid),
    .ptr (r_ptr),
    .any (w_rr_any),
    .idx (w_rr_idx)
  );

  assign w_cand = w_rr_mode ? w_rr_idx : sel;
  assign w_hit  = w_rr_mode ? w_rr_any : w_sel_valid;

  // Round-robin pointer: moves just past the winner on RR-mode grants only,
  // wrapping explicitly so non-power-of-two NUM stays in range.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with non-blocking
    // assignments so every flop samples pre-edge values.
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant && w_rr_mode) begin
      r_ptr <= (w_rr_idx == SELW'(NUM - 1)) ? '0 : w_rr_idx + SELW'(1);
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;

  assign w_cand = sel;
  assign w_hit  = w_sel_valid;
`endif

  // Grant only when the stage can take the beat and never during reset.
  assign w_grant = w_free && w_hit && !rst;

  // One-hot acceptance for the granted channel plus its data word.
  always_comb begin
    in_ready    = '0;
    w_cand_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_cand == SELW'(i)) begin
        in_ready[i] = w_grant;
        w_cand_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output stage: load on grant, empty when free without a grant, hold when
  // stalled. Data is reset too so the output is defined from reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
    end else if (w_free) begin
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_data <= w_cand_data;
        r_out_chan <= w_cand;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 4-channel and a 3-channel instance driven by
// directed vectors, with a spec-level model checked every cycle.
module tb_mux_sel_pipe;
  import mux_pkg::*;

  localparam int W = 32;
`ifdef MUX_SEL_PIPE_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM=4
  logic           a_rst;
  logic [4*W-1:0] a_in_data;
  logic [3:0]     a_in_valid, a_in_ready;
  logic [1:0]     a_sel;
  logic           a_mode;
  logic [W-1:0]   a_out_data;
  logic [1:0]     a_out_chan;
  logic           a_out_valid, a_out_ready;

  // Instance B: NUM=3
  logic           b_rst;
  logic [3*W-1:0] b_in_data;
  logic [2:0]     b_in_valid, b_in_ready;
  logic [1:0]     b_sel;
  logic           b_mode;
  logic [W-1:0]   b_out_data;
  logic [1:0]     b_out_chan;
  logic           b_out_valid, b_out_ready;

  mux_sel_pipe #(.WIDTH(W), .NUM(4)) u_dut4 (
    .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  mux_sel_pipe #(.WIDTH(W), .NUM(3)) u_dut3 (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what the output register holds plus the RR pointer.
  typedef struct {
    logic [W-1:0] data;
    int           chan;
    bit           valid;
    int           ptr;
  } mdl_t;

  mdl_t ma, mb;
  bit   chk_en = 1'b0;

  // Which channel the rules grant this cycle, or -1 for none.
  function automatic int pick(input int num, input logic [3:0] v, input int sel,
                              input logic mode, input logic rst, input mdl_t m,
                              input logic out_ready);
    if (rst) return -1;
    if (m.valid && !out_ready) return -1;
    if (RR_EN && mode) begin
      for (int k = 0; k < num; k++) begin
        if (v[(m.ptr + k) % num]) return (m.ptr + k) % num;
      end
      return -1;
    end
    if (sel < num && v[sel]) return sel;
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    return (g >= 0) ? 4'(1 << g) : 4'd0;
  endfunction

  // Advance the model at each rising edge from the inputs that were stable
  // throughout the cycle.
  always @(posedge clk) begin
    int ga, gb;
    ga = pick(4, a_in_valid, int'(a_sel), a_mode, a_rst, ma, a_out_ready);
    if (a_rst) begin
      ma.data = '0; ma.chan = 0; ma.valid = 1'b0; ma.ptr = 0;
    end else if (!ma.valid || a_out_ready) begin
      ma.valid = (ga >= 0);
      if (ga >= 0) begin
        ma.data = a_in_data[ga*W +: W];
        ma.chan = ga;
        if (RR_EN && a_mode) ma.ptr = (ga + 1) % 4;
      end
    end
    gb = pick(3, {1'b0, b_in_valid}, int'(b_sel), b_mode, b_rst, mb, b_out_ready);
    if (b_rst) begin
      mb.data = '0; mb.chan = 0; mb.valid = 1'b0; mb.ptr = 0;
    end else if (!mb.valid || b_out_ready) begin
      mb.valid = (gb >= 0);
      if (gb >= 0) begin
        mb.data = b_in_data[gb*W +: W];
        mb.chan = gb;
        if (RR_EN && b_mode) mb.ptr = (gb + 1) % 3;
      end
    end
  end

  // Compare both instances against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_in_ready", a_in_ready,
            onehot(pick(4, a_in_valid, int'(a_sel), a_mode, a_rst, ma, a_out_ready)));
      check("a_out_valid", a_out_valid, ma.valid);
      check("a_out_data",  a_out_data,  ma.data);
      check("a_out_chan",  a_out_chan,  ma.chan);
      check("b_in_ready", {1'b0, b_in_ready},
            onehot(pick(3, {1'b0, b_in_valid}, int'(b_sel), b_mode, b_rst, mb, b_out_ready)));
      check("b_out_valid", b_out_valid, mb.valid);
      check("b_out_data",  b_out_data,  mb.data);
      check("b_out_chan",  b_out_chan,  mb.chan);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    for (int i = 0; i < 4; i++) a_in_data[i*W +: W] = 32'hA000_0000 + i;
    for (int i = 0; i < 3; i++) b_in_data[i*W +: W] = 32'hB000_0000 + i;
    a_in_valid = 4'b1111; a_sel = 2'd0; a_mode = MODE_DIRECT; a_out_ready = 1'b1;
    b_in_valid = 3'b111;  b_sel = 2'd0; b_mode = MODE_DIRECT; b_out_ready = 1'b1;

    // Reset held for two cycles with every channel requesting.
    tick();
    chk_en = 1'b1;
    #1;
    check("rst_in_ready", a_in_ready, 4'b0000);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 32'h0);
    tick();
    check("rst2_in_ready", a_in_ready, 4'b0000);

    // First grant in the first cycle with reset low.
    a_rst = 1'b0; b_rst = 1'b0;
    #1 check("first_in_ready", a_in_ready, 4'b0001);
    tick();
    check("first_out_valid", a_out_valid, 1'b1);
    check("first_out_data", a_out_data, 32'hA000_0000);

    // Direct select of channel 2.
    a_in_data[2*W +: W] = 32'hDEAD_BEEF;
    a_in_valid = 4'b0100; a_sel = 2'd2;
    #1 check("dir_in_ready", a_in_ready, 4'b0100);
    tick();
    check("dir_out_data", a_out_data, 32'hDEAD_BEEF);
    check("dir_out_chan", a_out_chan, 2'd2);
    check("dir_out_valid", a_out_valid, 1'b1);

    // Backpressure for three cycles; mode/sel wiggle must not disturb the beat.
    a_out_ready = 1'b0; a_in_valid = 4'b1111; a_sel = 2'd1; a_mode = MODE_RR;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_in_ready", a_in_ready, 4'b0000);
      tick();
      check("bp_out_data", a_out_data, 32'hDEAD_BEEF);
      check("bp_out_chan", a_out_chan, 2'd2);
    end
    a_mode = MODE_DIRECT; a_out_ready = 1'b1;
    #1 check("bp_release_ready", a_in_ready, 4'b0010);
    tick();
    check("bp_release_chan", a_out_chan, 2'd1);
    check("bp_release_data", a_out_data, 32'hA000_0001);

    // Back-to-back grants at full rate.
    a_sel = 2'd3; tick(); check("tput_chan3", a_out_chan, 2'd3);
    a_sel = 2'd0; tick(); check("tput_chan0", a_out_chan, 2'd0);
    a_sel = 2'd2; tick(); check("tput_data2", a_out_data, 32'hDEAD_BEEF);

    // Free with nothing offered: valid falls, data and chan hold.
    a_in_valid = 4'b0000;
    tick();
    check("idle_out_valid", a_out_valid, 1'b0);
    check("idle_out_chan", a_out_chan, 2'd2);
    check("idle_out_data", a_out_data, 32'hDEAD_BEEF);

    // Reset while a beat is stalled drops it.
    a_in_valid = 4'b1111; a_sel = 2'd3;
    tick();
    a_out_ready = 1'b0; a_rst = 1'b1;
    #1 check("midrst_in_ready", a_in_ready, 4'b0000);
    tick();
    check("midrst_out_valid", a_out_valid, 1'b0);
    check("midrst_out_data", a_out_data, 32'h0);
    a_rst = 1'b0; a_out_ready = 1'b1;

`ifdef MUX_SEL_PIPE_RR_EN
    begin
      int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int exp_alt[3] = '{1, 3, 1};
      a_mode = MODE_RR; a_in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
        tick();
        check("rr_fair_chan", a_out_chan, exp_seq[i]);
      end
      a_in_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("rr_alt_chan", a_out_chan, exp_alt[i]);
      end
      // Direct grant leaves the pointer at 2.
      a_mode = MODE_DIRECT; a_sel = 2'd0; a_in_valid = 4'b0001;
      tick();
      a_mode = MODE_RR; a_in_valid = 4'b1111;
      #1 check("rr_ptr_hold_ready", a_in_ready, 4'b0100);
      tick();
    end
`else
    // Mode is ignored: direct select still applies.
    a_mode = MODE_RR; a_sel = 2'd1; a_in_valid = 4'b1111;
    #1 check("norr_in_ready", a_in_ready, 4'b0010);
    tick();
    check("norr_out_chan", a_out_chan, 2'd1);
`endif
    a_mode = MODE_DIRECT; a_in_valid = 4'b0000;

    // NUM=3: out-of-range select never grants.
    b_sel = 2'd1;
    tick();
    check("n3_out_chan", b_out_chan, 2'd1);
    b_sel = 2'd3;
    #1 check("n3_sel3_ready", {1'b0, b_in_ready}, 4'b0000);
    tick();
    check("n3_sel3_valid", b_out_valid, 1'b0);

`ifdef MUX_SEL_PIPE_RR_EN
    // Move ptr to 2, then skip empty channel 2 and wrap to 0.
    b_mode = MODE_RR; b_in_valid = 3'b010;
    tick();
    b_in_valid = 3'b011;
    #1 check("n3_wrap_ready", {1'b0, b_in_ready}, 4'b0001);
    tick();
    check("n3_wrap_chan", b_out_chan, 2'd0);
    b_in_valid = 3'b111;
    #1 check("n3_ptr1_ready", {1'b0, b_in_ready}, 4'b0010);
    tick();
    b_in_valid = 3'b100; tick();
    b_in_valid = 3'b111;
    #1 check("n3_ptr_wrap0", {1'b0, b_in_ready}, 4'b0001);
    tick();
`else
    b_mode = MODE_RR; b_sel = 2'd1;
    #1 check("n3_norr_ready", {1'b0, b_in_ready}, 4'b0010);
    tick();
    check("n3_norr_chan", b_out_chan, 2'd1);
`endif

    // Mixed traffic on both instances, checked by the model each cycle.
    for (int i = 0; i < 60; i++) begin
      a_in_valid  = 4'($urandom_range(0, 15));
      a_sel       = 2'($urandom_range(0, 3));
      a_mode      = 1'($urandom_range(0, 1));
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_data[(i % 4)*W +: W] = $urandom;
      b_in_valid  = 3'($urandom_range(0, 7));
      b_sel       = 2'($urandom_range(0, 3));
      b_mode      = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_in_data[(i % 3)*W +: W] = $urandom;
      tick();
    end

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
